// File: rtl/tlcd_responder.sv
// HD44780-style 2x16 character-LCD responder: samples the TLCD bus, keeps DDRAM/AC and a busy model.
// Optional build macro TLCD_READ_EN enables RW=1 reads (busy/address and DDRAM read-back).
module tlcd_responder #(
  parameter int unsigned EXEC_CYCLES  = 37,
  parameter int unsigned CLEAR_CYCLES = 1520,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             TLCD_E,
  input  logic             TLCD_RS,
  input  logic             TLCD_RW,
  input  logic [7:0]       TLCD_DATA,
  output logic [7:0]       TLCD_DATA_OUT,
  output logic [127:0]     LINE_UPPER,
  output logic [127:0]     LINE_LOWER,
  output logic             BUSY,
  output logic             DISP_ON,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int unsigned LINE_CHARS = 40;
  localparam int unsigned DEPTH      = 2 * LINE_CHARS;
  localparam int unsigned VIS_CHARS  = 16;
  localparam int unsigned MAX_CYC    = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);
  localparam logic [7:0]  SPACE      = 8'h20;

  logic             e_q;
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d;
  logic             disp_q, disp_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       ddram_q [DEPTH];
  logic [7:0]       ddram_d [DEPTH];

  logic       strobe;
  logic       viol;
  logic       load_exec;
  logic       load_clear;
  logic       wr_en;
  logic       clr_en;
  logic [6:0] wr_idx;

  // AC walks line 1 (0x00-0x27) and line 2 (0x40-0x67) as one 80-entry ring.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) r = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
    else     r = (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
    return r;
  endfunction

  function automatic logic [6:0] ddram_idx(input logic [6:0] ac);
    return ac[6] ? (7'(ac[5:0]) + 7'(LINE_CHARS)) : ac;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a < 7'h28) || ((a >= 7'h40) && (a < 7'h68));
  endfunction

  always_comb begin
    strobe     = e_q & ~TLCD_E;
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    err_d      = err_q;
    dout_d     = dout_q;
    cnt_d      = cnt_q;
    viol       = 1'b0;
    load_exec  = 1'b0;
    load_clear = 1'b0;
    wr_en      = 1'b0;
    clr_en     = 1'b0;
    wr_idx     = ddram_idx(ac_q);
    ddram_d    = ddram_q;

    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

    if (strobe) begin
      if (TLCD_RW) begin
`ifdef TLCD_READ_EN
        if (!TLCD_RS) begin
          dout_d = {busy_q, ac_q};
        end else if (busy_q) begin
          viol = 1'b1;
        end else begin
          dout_d    = ddram_q[ddram_idx(ac_q)];
          ac_d      = ac_step(ac_q, id_q);
          load_exec = 1'b1;
        end
`else
        viol = 1'b1;
`endif
      end else if (busy_q) begin
        viol = 1'b1;
      end else if (TLCD_RS) begin
        wr_en     = 1'b1;
        ac_d      = ac_step(ac_q, id_q);
        load_exec = 1'b1;
      end else if (TLCD_DATA[7]) begin
        if (addr_valid(TLCD_DATA[6:0])) begin
          ac_d      = TLCD_DATA[6:0];
          load_exec = 1'b1;
        end else begin
          viol = 1'b1;
        end
      end else if (TLCD_DATA[6:4] != 3'b000) begin
        // Function set, shift and CGRAM address are accepted but not modelled.
        load_exec = 1'b1;
      end else if (TLCD_DATA[3]) begin
        disp_d    = TLCD_DATA[2];
        load_exec = 1'b1;
      end else if (TLCD_DATA[2]) begin
        id_d      = TLCD_DATA[1];
        load_exec = 1'b1;
      end else if (TLCD_DATA[1]) begin
        ac_d       = 7'h00;
        load_clear = 1'b1;
      end else if (TLCD_DATA[0]) begin
        clr_en     = 1'b1;
        ac_d       = 7'h00;
        id_d       = 1'b1;
        load_clear = 1'b1;
      end else begin
        viol = 1'b1;
      end
    end

    if (load_exec)  cnt_d = CNT_W'(EXEC_CYCLES);
    if (load_clear) cnt_d = CNT_W'(CLEAR_CYCLES);
    busy_d = (cnt_d != '0);

    if (viol && (err_q != '1)) err_d = err_q + ERR_W'(1);

    if (clr_en)     ddram_d = '{default: SPACE};
    else if (wr_en) ddram_d[wr_idx] = TLCD_DATA;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      e_q     <= 1'b0;
      ac_q    <= 7'h00;
      id_q    <= 1'b1;
      disp_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      dout_q  <= 8'h00;
      ddram_q <= '{default: SPACE};
    end else begin
      e_q     <= TLCD_E;
      ac_q    <= ac_d;
      id_q    <= id_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      ddram_q <= ddram_d;
    end
  end

  // Visible window: first 16 cells of each line, blanked while the display is off.
  for (genvar g = 0; g < VIS_CHARS; g++) begin : g_win
    assign LINE_UPPER[8*(VIS_CHARS-1-g) +: 8] = disp_q ? ddram_q[g] : SPACE;
    assign LINE_LOWER[8*(VIS_CHARS-1-g) +: 8] = disp_q ? ddram_q[LINE_CHARS + g] : SPACE;
  end

  assign TLCD_DATA_OUT = dout_q;
  assign BUSY          = busy_q;
  assign DISP_ON       = disp_q;
  assign ERR_CNT       = err_q;

endmodule

// File: tb/tb_tlcd_responder.sv
// Scoreboard bench for tlcd_responder: directed bus sequences plus random traffic vs a cycle-timestamp model.
module tb_tlcd_responder;

  localparam int EXEC = 37;
  localparam int CLR  = 1520;
  localparam logic [127:0] SP = {16{8'h20}};

  typedef struct packed {
    logic [127:0] up;
    logic [127:0] lo;
    logic         busy;
    logic         disp;
    logic [7:0]   err;
    logic [7:0]   dout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         e = 1'b0;
  logic         rs = 1'b0;
  logic         rw = 1'b0;
  logic         probe_r = 1'b0;
  logic [7:0]   data = 8'h00;
  logic [7:0]   dout;
  logic [127:0] line_up, line_lo;
  logic         busy, disp_on;
  logic [7:0]   err_cnt;

  tlcd_responder #(.EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLR), .ERR_W(8)) dut (
    .CLK(clk), .RESETN(rst_n), .TLCD_E(e), .TLCD_RS(rs), .TLCD_RW(rw),
    .TLCD_DATA(data), .TLCD_DATA_OUT(dout), .LINE_UPPER(line_up),
    .LINE_LOWER(line_lo), .BUSY(busy), .DISP_ON(disp_on), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Model: DDRAM indexed by bus address; busy tracked as the strobe cycle where it ends.
  logic [7:0] mem [128];
  int         m_ac, m_err, m_busy_end;
  bit         m_id, m_disp;
  logic [7:0] m_dout;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mem[i] = 8'h20;
    m_ac = 0; m_id = 1; m_disp = 0; m_err = 0; m_dout = 8'h00; m_busy_end = -100000;
  endtask

  function automatic int next_ac(input int a, input bit inc);
    if (inc) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : a + 1;
    return (a == 0) ? 'h67 : (a == 'h40) ? 'h27 : a - 1;
  endfunction

  function automatic exp_t model_exp(input int s);
    exp_t x;
    for (int i = 0; i < 16; i++) begin
      x.up[127-8*i -: 8] = m_disp ? mem[i] : 8'h20;
      x.lo[127-8*i -: 8] = m_disp ? mem[64+i] : 8'h20;
    end
    x.busy = (s < m_busy_end);
    x.disp = m_disp;
    x.err  = 8'(m_err);
    x.dout = m_dout;
    return x;
  endfunction

  task automatic model_step(input bit rs_i, input bit rw_i, input logic [7:0] d, input int s);
    bit bz;
    bit viol;
    int n;
    int a;
    bz = (s <= m_busy_end);
    viol = 0;
    n = 0;
    a = int'(d[6:0]);
    if (rw_i) begin
`ifdef TLCD_READ_EN
      if (!rs_i) m_dout = {bz, 7'(m_ac)};
      else if (bz) viol = 1;
      else begin m_dout = mem[m_ac]; m_ac = next_ac(m_ac, m_id); n = EXEC; end
`else
      viol = 1;
`endif
    end else if (bz) viol = 1;
    else if (rs_i) begin mem[m_ac] = d; m_ac = next_ac(m_ac, m_id); n = EXEC; end
    else if (d >= 8'h80) begin
      if (a < 'h28 || (a >= 'h40 && a < 'h68)) begin m_ac = a; n = EXEC; end
      else viol = 1;
    end
    else if (d >= 8'h10) n = EXEC;
    else if (d >= 8'h08) begin m_disp = d[2]; n = EXEC; end
    else if (d >= 8'h04) begin m_id = d[1]; n = EXEC; end
    else if (d >= 8'h02) begin m_ac = 0; n = CLR; end
    else if (d == 8'h01) begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h20;
      m_ac = 0; m_id = 1; n = CLR;
    end
    else viol = 1;
    if (n != 0) m_busy_end = s + n;
    if (viol && m_err < 255) m_err++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input bit rs_i, input bit rw_i, input logic [7:0] d);
    int s;
    @(negedge clk); e = 1'b1; rs = rs_i; rw = rw_i; data = d;
    @(negedge clk); e = 1'b0;
    s = cyc + 1;
    model_step(rs_i, rw_i, d, s);
    sb.push_back(model_exp(s));
  endtask

  task automatic write_str(input string str);
    for (int i = 0; i < str.len(); i++) begin
      xfer(1'b1, 1'b0, str[i]);
      idle(38);
    end
  endtask

  task automatic cmd(input logic [7:0] d, input int gap);
    xfer(1'b0, 1'b0, d);
    idle(gap);
  endtask

  task automatic probe(input exp_t x);
    @(negedge clk); sb.push_back(x); probe_r = 1'b1;
    @(negedge clk); probe_r = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; e = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    sb.push_back('{up: SP, lo: SP, busy: 1'b0, disp: 1'b0, err: 8'h00, dout: 8'h00});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: one cycle after each strobe, reset release or probe, compare against the queue head.
  initial begin
    exp_t x;
    forever begin
      @(negedge e or posedge rst_n or posedge probe_r);
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_empty: got no expectation queued (t=%0t)", $time);
      end else begin
        x = sb.pop_front();
        chk("line_upper", line_up, x.up);
        chk("line_lower", line_lo, x.lo);
        chk("busy", 128'(busy), 128'(x.busy));
        chk("disp_on", 128'(disp_on), 128'(x.disp));
        chk("err_cnt", 128'(err_cnt), 128'(x.err));
        chk("data_out", 128'(dout), 128'(x.dout));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t;
    int k, gap;
    model_reset();
    do_reset();

    // Controller init sequence
    cmd(8'h38, 40); cmd(8'h0C, 40); cmd(8'h06, 40); cmd(8'h01, 1640); cmd(8'h80, 40);
    write_str("HELLO WORLD     ");
    cmd(8'hC0, 40);
    write_str("LINE2 TEXT 0123");
    probe('{up: "HELLO WORLD     ", lo: "LINE2 TEXT 0123 ", busy: 1'b0, disp: 1'b1, err: 8'd0, dout: 8'h00});

    // Write during busy, and the exact busy boundary
    do_reset();
    cmd(8'h0C, 40);
    xfer(1'b1, 1'b0, 8'h41); idle(8);
    xfer(1'b1, 1'b0, 8'h42); idle(25);
    xfer(1'b1, 1'b0, 8'h43);
    xfer(1'b1, 1'b0, 8'h44); idle(40);
    t = {"AD", {14{8'h20}}};
    probe('{up: t, lo: SP, busy: 1'b0, disp: 1'b1, err: 8'd2, dout: 8'h00});

    // Line wrap on increment and decrement, display off/on
    do_reset();
    cmd(8'h0C, 40); cmd(8'hA7, 40);
    xfer(1'b1, 1'b0, 8'h5A); idle(40);
    xfer(1'b1, 1'b0, 8'h5B); idle(40);
    t = {8'h5B, {15{8'h20}}};
    probe('{up: SP, lo: t, busy: 1'b0, disp: 1'b1, err: 8'd0, dout: 8'h00});
    cmd(8'h04, 40); cmd(8'hC0, 40);
    xfer(1'b1, 1'b0, 8'h58); idle(40);
    xfer(1'b1, 1'b0, 8'h59); idle(40);
    t = {8'h58, {15{8'h20}}};
    probe('{up: SP, lo: t, busy: 1'b0, disp: 1'b1, err: 8'd0, dout: 8'h00});
    cmd(8'h08, 40);
    probe('{up: SP, lo: SP, busy: 1'b0, disp: 1'b0, err: 8'd0, dout: 8'h00});
    cmd(8'h0C, 40);
    probe('{up: SP, lo: t, busy: 1'b0, disp: 1'b1, err: 8'd0, dout: 8'h00});

    // Clear busy window edges, then reset in the middle of a clear
    do_reset();
    cmd(8'h01, 998);
    cmd(8'h0C, 519);
    cmd(8'h0C, 38);
    cmd(8'h01, 1518);
    xfer(1'b1, 1'b0, 8'h41);
    xfer(1'b1, 1'b0, 8'h41); idle(40);
    t = {8'h41, {15{8'h20}}};
    probe('{up: t, lo: SP, busy: 1'b0, disp: 1'b1, err: 8'd2, dout: 8'h00});
    cmd(8'h01, 100);
    do_reset();

    // Busy/address read
    do_reset();
    cmd(8'hC5, 40);
    xfer(1'b0, 1'b1, 8'h00); idle(5);
`ifdef TLCD_READ_EN
    probe('{up: SP, lo: SP, busy: 1'b0, disp: 1'b0, err: 8'd0, dout: 8'h45});
`else
    probe('{up: SP, lo: SP, busy: 1'b0, disp: 1'b0, err: 8'd1, dout: 8'h00});
`endif

    // Random traffic
    do_reset();
    cmd(8'h0C, 40);
    for (int i = 0; i < 250; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 40)      xfer(1'b1, 1'b0, 8'($urandom));
      else if (k < 70) xfer(1'b0, 1'b0, 8'($urandom_range(0, 127)));
      else if (k < 85) xfer(1'b0, 1'b0, 8'($urandom_range(128, 255)));
      else if (k < 90) xfer(1'b0, 1'b0, 8'($urandom_range(0, 3)));
      else             xfer(1'($urandom), 1'b1, 8'($urandom));
      k = int'($urandom_range(0, 99));
      if (k < 60)      gap = int'($urandom_range(0, 40));
      else if (k < 95) gap = int'($urandom_range(33, 45));
      else             gap = int'($urandom_range(1515, 1525));
      idle(gap);
    end

    idle(5);
    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
